// File: rtl/reaction_pkg.sv
// Shared types and seven-segment constants for the reaction timer.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package reaction_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FOUL} state_t;

   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_S    = 7'h12;
   localparam logic [6:0] SEG_D    = 7'h21;
   localparam logic [6:0] SEG_F    = 7'h0E;

   function automatic logic [6:0] hex_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..TICK_DIV-1, tick high while at TICK_DIV-1.
// clear restarts the count so the next millisecond is full length; no backpressure.
module ms_tick #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game core: start arms a delay, react reports elapsed ms or a false start.
// Outputs registered, hex lags state by one cycle; best_ms tracking built only with REACTION_BEST_EN.
module reaction_timer
   import reaction_pkg::*;
#(
   parameter int TICK_DIV      = 50000,
   parameter int SEL_W         = 4,
   parameter int DELAY_BASE_MS = 1000,
   parameter int DELAY_STEP_MS = 125,
   parameter int CNT_W         = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEL_W-1:0] sel,
   input  logic             start,
   input  logic             react,
   output logic [6:0]       hex,
   output logic [CNT_W-1:0] result_ms,
   output logic             result_valid,
   output logic             false_start,
   output logic             busy,
   output logic [CNT_W-1:0] best_ms
);

   localparam logic [CNT_W-1:0] BASE    = CNT_W'(DELAY_BASE_MS);
   localparam logic [CNT_W-1:0] STEP    = CNT_W'(DELAY_STEP_MS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             start_q, react_q;
   logic             start_edge, react_edge;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] delay_q, ms_cnt;
   logic             tick, clear_pre, launch, hit;
   logic [6:0]       hex_d;

   assign start_edge = start & ~start_q;
   assign react_edge = react & ~react_q;
   assign hit        = (state_q == GO) && react_edge;

   ms_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .reset(reset),
      .clear(clear_pre),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (start_edge) state_d = WAIT;
         // a react edge wins even on the cycle the delay expires
         WAIT:       if (react_edge) state_d = FOUL;
                     else if (tick && ms_cnt == delay_q - CNT_W'(1)) state_d = GO;
         GO:         if (react_edge) state_d = DONE;
         DONE, FOUL: if (start_edge) state_d = WAIT;
         default:    state_d = IDLE;
      endcase
      launch    = (state_d == WAIT) && (state_q != WAIT);
      clear_pre = (state_d != state_q) && (state_d == WAIT || state_d == GO);
   end

   always_comb begin
      hex_d = SEG_DASH;
      case (state_q)
         WAIT:    hex_d = hex_seg(4'(sel_q));
         GO:      hex_d = SEG_S;
         DONE:    hex_d = SEG_D;
         FOUL:    hex_d = SEG_F;
         default: hex_d = SEG_DASH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         react_q      <= 1'b0;
         sel_q        <= '0;
         delay_q      <= '0;
         ms_cnt       <= '0;
         result_ms    <= '0;
         result_valid <= 1'b0;
         false_start  <= 1'b0;
         busy         <= 1'b0;
         hex          <= SEG_DASH;
      end else begin
         state_q      <= state_d;
         start_q      <= start;
         react_q      <= react;
         result_valid <= hit;
         false_start  <= (state_d == FOUL);
         busy         <= (state_d == WAIT) || (state_d == GO);
         hex          <= hex_d;
         if (hit)
            result_ms <= ms_cnt;
         if (launch) begin
            sel_q   <= sel;
            delay_q <= BASE + CNT_W'(sel) * STEP;
         end
         if (clear_pre)
            ms_cnt <= '0;
         else if (tick && (state_q == WAIT || (state_q == GO && ms_cnt != CNT_MAX)))
            ms_cnt <= ms_cnt + CNT_W'(1);
      end
   end

`ifdef REACTION_BEST_EN
   logic [CNT_W-1:0] best_q;

   always_ff @(posedge clk) begin
      if (reset)
         best_q <= '1;
      else if (hit && ms_cnt < best_q)
         best_q <= ms_cnt;
   end

   assign best_ms = best_q;
`else
   assign best_ms = '1;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with a result scoreboard (TICK_DIV=4, delay = 2 + sel ms, CNT_W=4).
module tb_reaction_timer;

   localparam int CNT_W = 4;
`ifdef REACTION_BEST_EN
   localparam bit BEST_EN = 1'b1;
`else
   localparam bit BEST_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [3:0]       sel = 4'd3;
   logic             start = 1'b0;
   logic             react = 1'b0;
   logic [6:0]       hex;
   logic [CNT_W-1:0] result_ms;
   logic             result_valid;
   logic             false_start;
   logic             busy;
   logic [CNT_W-1:0] best_ms;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int e;

   reaction_timer #(
      .TICK_DIV(4), .SEL_W(4), .DELAY_BASE_MS(2), .DELAY_STEP_MS(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .sel(sel), .start(start), .react(react),
      .hex(hex), .result_ms(result_ms), .result_valid(result_valid),
      .false_start(false_start), .busy(busy), .best_ms(best_ms)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // drives one start edge; returns in the first WAIT cycle
   task automatic start_round(input logic [3:0] s);
      sel   = s;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_hex"}, 16'(hex), 16'h3F);
      chk({tag, "_result_ms"}, 16'(result_ms), 16'h0);
      chk({tag, "_result_valid"}, 16'(result_valid), 16'h0);
      chk({tag, "_false_start"}, 16'(false_start), 16'h0);
      chk({tag, "_busy"}, 16'(busy), 16'h0);
      chk({tag, "_best"}, 16'(best_ms), 16'hF);
   endtask

   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         total++;
         assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL unexpected_result_valid: observed=%0d expected=no result", result_ms);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert (result_ms === CNT_W'(e)) else begin
               bad++;
               $error("FAIL scoreboard_result: observed=%0d expected=%0d", result_ms, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rs[3];
      int bs[3];
      rs = '{7, 4, 9};
      bs = '{7, 4, 4};

      step(3);
      chk_reset_outputs("reset");
      reset = 1'b0;
      step(1);

      // GO exactly 20 cycles after WAIT entry; sel change during WAIT ignored
      start_round(4'd3);
      chk("wait_busy", 16'(busy), 16'h1);
      sel = 4'd9;
      step(1);
      chk("wait_hex_sel", 16'(hex), 16'h30);
      step(18);
      chk("wait_hex_before_go", 16'(hex), 16'h30);
      step(1);
      chk("go_entry_hex_lag", 16'(hex), 16'h30);
      step(1);
      chk("go_hex", 16'(hex), 16'h12);
      step(12);
      react = 1'b1;
      exp_q.push_back(3);
      step(1);
      chk("react13_valid", 16'(result_valid), 16'h1);
      chk("react13_result", 16'(result_ms), 16'h3);
      chk("done_busy", 16'(busy), 16'h0);
      react = 1'b0;
      step(1);
      chk("valid_single_pulse", 16'(result_valid), 16'h0);
      chk("done_hex", 16'(hex), 16'h21);
      chk("best_after_3", 16'(best_ms), BEST_EN ? 16'h3 : 16'hF);

      // false start during WAIT
      start_round(4'd3);
      chk("foul1_busy", 16'(busy), 16'h1);
      step(5);
      react = 1'b1;
      step(1);
      chk("foul1_false_start", 16'(false_start), 16'h1);
      chk("foul1_busy_low", 16'(busy), 16'h0);
      react = 1'b0;
      step(1);
      chk("foul1_hex", 16'(hex), 16'h0E);
      chk("foul1_no_valid", 16'(result_valid), 16'h0);

      // react edge on the exact cycle WAIT would become GO
      start_round(4'd3);
      chk("foul2_cleared", 16'(false_start), 16'h0);
      step(19);
      react = 1'b1;
      step(1);
      chk("foul2_false_start", 16'(false_start), 16'h1);
      react = 1'b0;
      step(1);
      chk("foul2_hex", 16'(hex), 16'h0E);

      // counter saturation
      start_round(4'd3);
      step(20);
      step(400);
      react = 1'b1;
      exp_q.push_back(15);
      step(1);
      chk("sat_valid", 16'(result_valid), 16'h1);
      chk("sat_result", 16'(result_ms), 16'hF);
      react = 1'b0;
      step(1);
      chk("best_after_sat", 16'(best_ms), BEST_EN ? 16'h3 : 16'hF);

      // reset in GO abandons the round
      start_round(4'd3);
      step(22);
      chk("pre_reset_busy", 16'(busy), 16'h1);
      reset = 1'b1;
      step(1);
      chk_reset_outputs("reset_in_go");
      reset = 1'b0;
      step(1);

      // best tracking over 7, 4, 9 ms rounds
      for (int i = 0; i < 3; i++) begin
         start_round(4'd3);
         step(20);
         step(4 * rs[i] + 1);
         react = 1'b1;
         exp_q.push_back(rs[i]);
         step(1);
         chk($sformatf("best_round%0d_valid", i), 16'(result_valid), 16'h1);
         chk($sformatf("best_round%0d_best", i), 16'(best_ms), BEST_EN ? 16'(bs[i]) : 16'hF);
         react = 1'b0;
         step(2);
      end

      step(2);
      chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Parametrised reaction-time game core for the FPGA mini-games board. A start press arms a selectable random-looking delay, the seven-segment digit shows the selected delay code during the wait, then shows "S" when the player may react. The react press ends the round and reports the elapsed milliseconds. Pressing early is flagged as a false start. It sits between the debounced push-button/switch inputs and the HEX display and result decoders.

## Interface
- TICK_DIV, 50000: clk cycles per millisecond tick (50 MHz board clock)
- SEL_W, 4: width of delay-select input
- DELAY_BASE_MS, 1000: delay for sel = 0
- DELAY_STEP_MS, 125: delay increment per sel step
- CNT_W, 14: width of millisecond counters and result
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sel  in  SEL_W  delay code, latched on start edge
- start  in  1  debounced start button, level, active-high
- react  in  1  debounced react button, level, active-high
- hex  out  7  active-low segments, bit 6 = g … bit 0 = a
- result_ms  out  CNT_W  last reaction time in ms
- result_valid  out  1  one-cycle pulse when result_ms updates
- false_start  out  1  high while in FOUL
- busy  out  1  high in WAIT or GO
- best_ms  out  CNT_W  best (minimum) reaction since reset

## Operation
- One clock, clk; reset synchronous and active-high.
- start and react rising edges detected internally via one register stage each (edge = input high now, low previous cycle).
- Delay in ms = DELAY_BASE_MS + sel × DELAY_STEP_MS, computed at CNT_W bits, latched on the start edge; sel changes afterwards have no effect.
- States: IDLE, WAIT, GO, DONE, FOUL.
- IDLE: hex = "-". start edge → WAIT.
- WAIT: hex = hex digit of latched sel (0–F). Tick counter counts ms; on the tick where count reaches delay−1 → GO. react edge → FOUL (priority over the GO transition in the same cycle). start edge ignored.
- GO: hex = "S". Reaction counter increments per tick, saturating at 2^CNT_W−1. react edge → DONE; result_ms ← counter; result_valid pulses. start edge ignored.
- DONE: hex = "d". FOUL: hex = "F", false_start = 1. start edge from either → WAIT (new round, sel re-latched, counters cleared).
- Reset: state IDLE, hex = "-" (7'b0111111), result_ms = 0, result_valid = 0, false_start = 0, busy = 0, best_ms = all ones, edge registers = 0.
- Reset mid-round abandons the round without asserting result_valid.

## Timing
- Prescaler counts 0..TICK_DIV−1, tick when at TICK_DIV−1; cleared on entry to WAIT and GO, so the first ms is full length.
- GO entered exactly delay × TICK_DIV cycles after the cycle WAIT is entered.
- react rising at cycle N (first high sample) → state DONE, result_valid = 1 and result_ms valid at cycle N+1; result_valid low at N+2.
- result_ms = whole ms elapsed in GO (truncated); react within the first ms reports 0.
- All outputs registered; hex changes one cycle after the state change.

## Configuration
- REACTION_BEST_EN defined: best_ms updates in the same cycle as result_valid when the new result_ms < best_ms; FOUL rounds never update it.
- Not defined: best_ms tied to all ones, no comparator or register.

## Structure
- reaction_pkg: state enum, seven-segment constants (dash, S, d, F, hex digits 0–F), segment-lookup function.
- Sub-module ms_tick: prescaler with clear input and one-cycle tick output, parameter TICK_DIV.

## Test plan
- TICK_DIV = 4, DELAY_BASE_MS = 2, DELAY_STEP_MS = 1, sel = 3: start edge → GO entered exactly 20 cycles after WAIT entry, hex = "S".
- Same configuration, react 13 cycles after GO entry → result_ms = 3, result_valid single pulse, hex = "d".
- react during WAIT, and separately on the exact GO-transition cycle → FOUL, false_start = 1, hex = "F", no result_valid.
- CNT_W = 4, react withheld 100 ticks → result_ms = 15 (saturated).
- REACTION_BEST_EN, rounds of 7, 4, 9 ms → best_ms = 7, 4, 4. Without the macro, best_ms = 15 throughout.
- reset asserted in GO → IDLE next cycle, all outputs at reset values; sel change during WAIT does not alter delay.
